// File: rtl/mac_operand_feeder.sv
// Splits a packed A word into SINGLE/DUAL/QUAD multiplier beats; first beat one cycle after accept, registered outputs.
// Backpressure: beats hold while out_ready is low; a new word is taken only when idle or as the last beat retires.
module mac_operand_feeder #(
  parameter int MIN_W  = 8,
  parameter int CONF_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*MIN_W-1:0]   in_a,
  input  logic [MIN_W-1:0]     in_b,
  input  logic [CONF_W-1:0]    in_cfg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MIN_W-1:0]     out_a0,
  output logic [MIN_W-1:0]     out_a1,
  output logic [MIN_W-1:0]     out_a2,
  output logic [MIN_W-1:0]     out_a3,
  output logic [MIN_W-1:0]     out_b1,
  output logic [CONF_W-1:0]    out_cfg,
  output logic                 out_last,
  output logic                 err_cfg
);

  localparam logic [CONF_W-1:0] CFG_SINGLE = CONF_W'(0);
  localparam logic [CONF_W-1:0] CFG_DUAL   = CONF_W'(1);
  localparam logic [CONF_W-1:0] CFG_QUAD   = CONF_W'(2);

  typedef enum logic {IDLE, ISSUE} state_t;

  typedef struct packed {
    logic [MIN_W-1:0] a3;
    logic [MIN_W-1:0] a2;
    logic [MIN_W-1:0] a1;
    logic [MIN_W-1:0] a0;
    logic             last;
  } beat_t;

  state_t             state;
  logic [1:0]         k;
  logic [4*MIN_W-1:0] hold_a;
  beat_t              cur;
  beat_t              first_beat;
  beat_t              next_beat;
  logic               acc;
  logic               fire;
  logic               reserved;

  // Lane placement for beat k of a word in mode cfg.
  function automatic beat_t make_beat(input logic [4*MIN_W-1:0] a,
                                      input logic [CONF_W-1:0] cfg,
                                      input logic [1:0] kk);
    beat_t bt;
    bt = '0;
    case (cfg)
      CFG_SINGLE: begin
        bt.a1   = a[MIN_W*int'(kk) +: MIN_W];
        bt.last = (kk == 2'd3);
      end
      CFG_DUAL: begin
        bt.a0   = a[MIN_W*(2*int'(kk[0])) +: MIN_W];
        bt.a1   = a[MIN_W*(2*int'(kk[0])+1) +: MIN_W];
        bt.last = kk[0];
      end
      default: begin
        bt.a0   = a[0*MIN_W +: MIN_W];
        bt.a1   = a[1*MIN_W +: MIN_W];
        bt.a2   = a[2*MIN_W +: MIN_W];
        bt.a3   = a[3*MIN_W +: MIN_W];
        bt.last = 1'b1;
      end
    endcase
    return bt;
  endfunction

  always_comb begin
    first_beat = make_beat(in_a, in_cfg, 2'd0);
    next_beat  = make_beat(hold_a, out_cfg, k + 2'd1);
  end

  assign fire     = out_valid && out_ready;
  assign in_ready = !rst && (state == IDLE || (fire && cur.last));
  assign acc      = in_valid && in_ready;
  assign reserved = !(in_cfg == CFG_SINGLE || in_cfg == CFG_DUAL || in_cfg == CFG_QUAD);

  assign out_a0   = cur.a0;
  assign out_a1   = cur.a1;
  assign out_a2   = cur.a2;
  assign out_a3   = cur.a3;
  assign out_last = cur.last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= 2'd0;
      hold_a    <= '0;
      cur       <= '0;
      out_valid <= 1'b0;
      out_b1    <= '0;
      out_cfg   <= '0;
      err_cfg   <= 1'b0;
    end else begin
      err_cfg <= 1'b0;
      if (acc) begin
        hold_a <= in_a;
        k      <= 2'd0;
        // Reserved modes are swallowed: flag it and stay idle.
        if (reserved) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          cur       <= '0;
          out_b1    <= '0;
          out_cfg   <= '0;
          err_cfg   <= 1'b1;
        end else begin
          state     <= ISSUE;
          out_valid <= 1'b1;
          cur       <= first_beat;
          out_b1    <= in_b;
          out_cfg   <= in_cfg;
        end
      end else if (fire) begin
        if (cur.last) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          k         <= 2'd0;
          cur       <= '0;
          out_b1    <= '0;
          out_cfg   <= '0;
        end else begin
          k   <= k + 2'd1;
          cur <= next_beat;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Scoreboarded bench for mac_operand_feeder: directed cases then random traffic with random out_ready.
// A word-level model expands each accepted word into expected beats; a monitor pops and compares.
module tb_mac_operand_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [7:0]  in_b = '0;
  logic [1:0]  in_cfg = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_a0, out_a1, out_a2, out_a3, out_b1;
  logic [1:0]  out_cfg;
  logic        out_last;
  logic        err_cfg;

  always #5 clk = ~clk;

  mac_operand_feeder #(.MIN_W(8), .CONF_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cfg(in_cfg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a0(out_a0), .out_a1(out_a1), .out_a2(out_a2), .out_a3(out_a3),
    .out_b1(out_b1), .out_cfg(out_cfg), .out_last(out_last),
    .err_cfg(err_cfg)
  );

  typedef struct packed {
    logic [7:0] a3, a2, a1, a0, b;
    logic [1:0] cfg;
    logic       last;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;
  bit   err_exp = 1'b0;
  bit   chk_zero = 1'b0;
  bit   rdy_rand = 1'b0;
  bit   rdy_force = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Word model: mode c carries 1<<c bytes per beat; SINGLE uses lane 1, others start at lane 0.
  task automatic push_word(input logic [31:0] a, input logic [7:0] b, input logic [1:0] c);
    int per, nb, start;
    logic [7:0] ln [4];
    exp_t e;
    per   = 1 << int'(c);
    nb    = 4 / per;
    start = (c == 2'd0) ? 1 : 0;
    for (int kb = 0; kb < nb; kb++) begin
      for (int l = 0; l < 4; l++) ln[l] = 8'h00;
      for (int j = 0; j < per; j++) ln[start+j] = a[8*(kb*per+j) +: 8];
      e.a0 = ln[0]; e.a1 = ln[1]; e.a2 = ln[2]; e.a3 = ln[3];
      e.b = b; e.cfg = c; e.last = (kb == nb - 1);
      q.push_back(e);
    end
  endtask

  task automatic monitor();
    exp_t cur;
    forever begin
      @(negedge clk);
      if (chk_zero) begin
        chk("reset_outputs", 64'({out_valid, out_last, err_cfg, out_a3, out_a2, out_a1, out_a0, out_b1, out_cfg}), 64'd0);
        chk_zero = 1'b0;
      end
      if (rst) begin
        chk("in_ready_in_reset", 64'(in_ready), 64'd0);
        q.delete();
        err_exp  = 1'b0;
        chk_zero = 1'b1;
      end else begin
        chk("err_cfg", 64'(err_cfg), 64'(err_exp));
        err_exp = 1'b0;
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() == 0 || (q.size() == 1 && out_ready)));
        if (out_valid && q.size() != 0) begin
          cur.a0 = out_a0; cur.a1 = out_a1; cur.a2 = out_a2; cur.a3 = out_a3;
          cur.b = out_b1; cur.cfg = out_cfg; cur.last = out_last;
          if (out_ready) begin
            chk("beat", 64'(cur), 64'(q[0]));
            void'(q.pop_front());
            hs_cnt++;
          end else begin
            chk("stall_hold", 64'(cur), 64'(q[0]));
          end
        end
        if (in_valid && in_ready) begin
          if (in_cfg == 2'd3) err_exp = 1'b1;
          else push_word(in_a, in_b, in_cfg);
        end
      end
    end
  endtask

  task automatic rdy_drive();
    forever begin
      @(posedge clk);
      #2;
      out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  endtask

  // Leaves in_valid high on return so consecutive calls can stream without gaps.
  task automatic send(input logic [31:0] a, input logic [7:0] b, input logic [1:0] c, output int waits);
    bit acc;
    acc = 1'b0;
    waits = 0;
    in_valid = 1'b1; in_a = a; in_b = b; in_cfg = c;
    for (int n = 0; n < 100 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      if (!acc) waits++;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=no_accept required=accept cfg=%0d", c);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w, h0;
    logic [7:0] exp_s [4];
    exp_s[0] = 8'hAA; exp_s[1] = 8'hBB; exp_s[2] = 8'hCC; exp_s[3] = 8'hDD;
    fork
      monitor();
      rdy_drive();
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    rdy_force = 1'b1;
    step();

    // QUAD single beat
    send(32'h44332211, 8'h05, 2'd2, w);
    in_valid = 1'b0;
    @(negedge clk);
    chk("quad_lanes", 64'({out_a3, out_a2, out_a1, out_a0}), 64'h44332211);
    chk("quad_b1", 64'(out_b1), 64'h05);
    chk("quad_last", 64'(out_last), 64'd1);
    step(); step();

    // SINGLE: four beats on lane 1
    send(32'hDDCCBBAA, 8'h3C, 2'd0, w);
    in_valid = 1'b0;
    for (int kb = 0; kb < 4; kb++) begin
      @(negedge clk);
      chk("single_a1", 64'(out_a1), 64'(exp_s[kb]));
      chk("single_other", 64'({out_a3, out_a2, out_a0}), 64'd0);
      chk("single_last", 64'(out_last), 64'(kb == 3));
      chk("single_in_ready", 64'(in_ready), 64'(kb == 3));
      step();
    end
    step();

    // DUAL with beat 0 stalled for three cycles
    rdy_force = 1'b0;
    step();
    h0 = hs_cnt;
    send(32'h87654321, 8'h09, 2'd1, w);
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("dual_hold", 64'({out_a1, out_a0}), 64'h4321);
      @(posedge clk);
    end
    rdy_force = 1'b1;
    @(negedge clk);
    chk("dual_beat0", 64'({out_a1, out_a0}), 64'h4321);
    step();
    @(negedge clk);
    chk("dual_beat1", 64'({out_a1, out_a0}), 64'h8765);
    chk("dual_last", 64'(out_last), 64'd1);
    step(); step();
    chk("dual_handshakes", 64'(hs_cnt - h0), 64'd2);

    // Three QUAD words back to back
    h0 = hs_cnt;
    send(32'h01020304, 8'h11, 2'd2, w);
    send(32'h05060708, 8'h22, 2'd2, w);
    chk("b2b_wait2", 64'(w), 64'd0);
    send(32'h090A0B0C, 8'h33, 2'd2, w);
    chk("b2b_wait3", 64'(w), 64'd0);
    in_valid = 1'b0;
    step(); step();
    chk("b2b_handshakes", 64'(hs_cnt - h0), 64'd3);

    // Reserved cfg dropped, then a normal QUAD word
    send(32'hCAFEF00D, 8'h77, 2'd3, w);
    in_valid = 1'b0;
    @(negedge clk);
    chk("err_pulse", 64'(err_cfg), 64'd1);
    chk("err_no_valid", 64'(out_valid), 64'd0);
    step();
    @(negedge clk);
    chk("err_drop", 64'(err_cfg), 64'd0);
    step();
    send(32'hA1B2C3D4, 8'h42, 2'd2, w);
    in_valid = 1'b0;
    step(); step();

    // Reset during beat 2 of a SINGLE word
    send(32'h12345678, 8'h66, 2'd0, w);
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_beat2_a1", 64'(out_a1), 64'h34);
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", 64'(in_ready), 64'd1);
    chk("rst_no_beats", 64'(out_valid), 64'd0);
    step();

    // Random traffic with random backpressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) step();
      end
      send($urandom, 8'($urandom), ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)), w);
    end
    in_valid = 1'b0;
    rdy_rand = 1'b0;
    rdy_force = 1'b1;
    for (int n = 0; n < 50 && q.size() != 0; n++) step();
    step();
    chk("drain_empty", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_operand_feeder.md
MAC_OPERAND_FEEDER -- requirements
Module: mac_operand_feeder

Interface
REQ-001 SHALL have parameter MIN_W, default 8: lane width; equals MAC_MIN_WIDTH from mac_const.vh.
REQ-002 SHALL have parameter CONF_W, default 2: config width; equals MAC_CONF_WIDTH.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  in  1  upstream word valid.
REQ-006 SHALL have port in_ready  out  1  feeder can accept a word this cycle.
REQ-007 SHALL have port in_a  in  4*MIN_W  packed A operand word.
REQ-008 SHALL have port in_b  in  MIN_W  B operand, shared by all beats of the word.
REQ-009 SHALL have port in_cfg  in  CONF_W  mode: 0=SINGLE, 1=DUAL, 2=QUAD, 3=reserved.
REQ-010 SHALL have port out_valid  out  1  beat valid toward the multiply block.
REQ-011 SHALL have port out_ready  in  1  downstream accepts the beat.
REQ-012 SHALL have ports out_a0, out_a1, out_a2, out_a3  out  MIN_W each  multiplier A lanes.
REQ-013 SHALL have port out_b1  out  MIN_W  multiplier B lane.
REQ-014 SHALL have port out_cfg  out  CONF_W  mode of the current beat.
REQ-015 SHALL have port out_last  out  1  final beat of the current word.
REQ-016 SHALL have port err_cfg  out  1  one-cycle pulse when a reserved-cfg word is dropped.

Function
REQ-017 SHALL use a two-state FSM, IDLE and ISSUE, plus a 2-bit beat counter.
REQ-018 SHALL drive in_ready = !rst && (state==IDLE || (out_valid && out_ready && out_last)).
REQ-019 SHALL capture in_a, in_b and in_cfg into a holding register on in_valid && in_ready, and SHALL NOT capture otherwise.
REQ-020 SHALL give a valid-cfg word N beats: SINGLE 4, DUAL 2, QUAD 1.
REQ-021 SHALL assert out_valid on the cycle after acceptance, with beat counter k=0; there is no combinational path from in_* to out_*.
REQ-022 SHALL issue SINGLE beat k as out_a1 = in_a[8k+7:8k], with out_a0, out_a2, out_a3 = 0 (for MIN_W=8).
REQ-023 SHALL issue DUAL beat k as out_a0 = byte 2k and out_a1 = byte 2k+1, with out_a2, out_a3 = 0.
REQ-024 SHALL issue the QUAD beat as out_a0..out_a3 = bytes 0..3.
REQ-025 SHALL drive out_b1 = held in_b and out_cfg = held in_cfg on every beat.
REQ-026 SHALL assert out_last when k = N-1.
REQ-027 SHALL advance k only on out_valid && out_ready.
REQ-028 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-029 SHALL, on acceptance of the last beat with no new word, return to IDLE, deassert out_valid the next cycle, and zero out_a* and out_b1.
REQ-030 SHALL, when the last beat is accepted and a new word is accepted in the same cycle, present the new word's beat 0 the next cycle, with no bubble.
REQ-031 SHALL sustain QUAD words back-to-back at one beat per cycle.
REQ-032 SHALL, on a reserved cfg, accept the word, issue no beat, pulse err_cfg for exactly one cycle the next cycle, and remain/return to IDLE.
REQ-033 SHALL ignore out_ready while out_valid=0.

Reset
REQ-034 SHALL, when rst=1 at a clock edge, set state=IDLE, k=0 and out_valid=0, and set out_last, err_cfg, out_a0..out_a3, out_b1 and out_cfg all to 0.
REQ-035 SHALL, on reset mid-word, discard remaining beats, with in_ready=0 while rst=1 and in_ready=1 on the first cycle after rst drops.

Verification
REQ-036 SHALL verify: QUAD, in_a=0x44332211, in_b=0x05, out_ready=1 -> one beat next cycle with a0..a3 = 11,22,33,44 (hex), b1=05, out_last=1.
REQ-037 SHALL verify: SINGLE, in_a=0xDDCCBBAA, out_ready=1 -> 4 consecutive beats with out_a1 = AA, BB, CC, DD, other lanes 0, out_last on beat 4 only, in_ready=1 on beat 4.
REQ-038 SHALL verify: DUAL, in_a=0x87654321, out_ready low for 3 cycles on beat 0 -> (a0,a1)=(21,43) held stable, then (65,87), with exactly 2 handshakes.
REQ-039 SHALL verify: 3 QUAD words with in_valid=1 continuously and out_ready=1 -> 3 beats on 3 consecutive cycles, no bubble.
REQ-040 SHALL verify: in_cfg=3 -> err_cfg high exactly one cycle, out_valid stays 0, and a following QUAD word is issued normally.
REQ-041 SHALL verify: rst=1 during beat 2 of a SINGLE word -> all outputs 0 next cycle, no further beats, in_ready=1 one cycle after rst drops.
